fir_mc_serial: RTL

Multi-channel, time-multiplexed FIR filter with a single shared multiply-accumulate unit, run-time programmable coefficients and valid/ready handshakes on both data ports. Each channel keeps its own delay line. One coefficient bank is shared by all channels. Results are rounded and saturated to the output width. It replaces the fully parallel fixed-coefficient FIR in datapaths where area matters more than throughput and several interleaved streams share one filter.

---
 rtl/fir_pkg.sv | 16 +
 rtl/fir_round_sat.sv | 36 +++
 rtl/fir_mc_serial.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared types and elaboration helpers for the time-multiplexed FIR family.
package fir_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      HOLD = 2'd2
   } state_t;

   // True when the accumulator can hold a full sum of NUM_TAPS products without wrapping.
   function automatic bit acc_width_ok(input int acc_w, input int in_w, input int coef_w,
                                       input int taps);
      return acc_w >= in_w + coef_w + $clog2(taps);
   endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up by FRAC_BITS then saturate to OUT_WIDTH signed; purely combinational.
module fir_round_sat #(
   parameter int ACC_WIDTH = 24,
   parameter int FRAC_BITS = 7,
   parameter int OUT_WIDTH = 8
) (
   input  logic signed [ACC_WIDTH-1:0] i_acc,
   output logic signed [OUT_WIDTH-1:0] o_value,
   output logic                        o_sat
);

   localparam logic signed [ACC_WIDTH:0] C_HALF =
      (FRAC_BITS > 0) ? ((ACC_WIDTH+1)'(1) << ((FRAC_BITS > 0) ? FRAC_BITS - 1 : 0)) : '0;
   localparam logic signed [ACC_WIDTH:0] C_MAX = (ACC_WIDTH+1)'((2 ** (OUT_WIDTH - 1)) - 1);
   localparam logic signed [ACC_WIDTH:0] C_MIN = -C_MAX - (ACC_WIDTH+1)'(1);

   // One guard bit so adding the half-LSB can never wrap.
   logic signed [ACC_WIDTH:0] w_biased;
   logic signed [ACC_WIDTH:0] w_shift;

   assign w_biased = (ACC_WIDTH+1)'(i_acc) + C_HALF;
   assign w_shift  = w_biased >>> FRAC_BITS;

   always_comb begin
      o_sat   = 1'b0;
      o_value = w_shift[OUT_WIDTH-1:0];
      if (w_shift > C_MAX) begin
         o_value = C_MAX[OUT_WIDTH-1:0];
         o_sat   = 1'b1;
      end else if (w_shift < C_MIN) begin
         o_value = C_MIN[OUT_WIDTH-1:0];
         o_sat   = 1'b1;
      end
   end

endmodule

// File: rtl/fir_mc_serial.sv
// Multi-channel FIR with one shared MAC: per-channel delay lines, a common
// programmable coefficient bank, valid/ready on input and output.
module fir_mc_serial
   import fir_pkg::*;
#(
   parameter int IN_WIDTH    = 8,
   parameter int COEFF_WIDTH = 8,
   parameter int OUT_WIDTH   = 8,
   parameter int NUM_TAPS    = 13,
   parameter int NUM_CH      = 2,
   parameter int ACC_WIDTH   = 24,
   parameter int FRAC_BITS   = 7
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic                                           in_valid,
   output logic                                           in_ready,
   input  logic signed [IN_WIDTH-1:0]                     in_data,
   input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] in_ch,
   input  logic                                           coef_we,
   input  logic [$clog2(NUM_TAPS)-1:0]                    coef_addr,
   input  logic signed [COEFF_WIDTH-1:0]                  coef_data,
   output logic                                           coef_err,
   output logic                                           out_valid,
   input  logic                                           out_ready,
   output logic signed [OUT_WIDTH-1:0]                    out_data,
   output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] out_ch,
   output logic                                           out_sat
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int K_W  = $clog2(NUM_TAPS);
   localparam int P_W  = IN_WIDTH + COEFF_WIDTH;

   if (!acc_width_ok(ACC_WIDTH, IN_WIDTH, COEFF_WIDTH, NUM_TAPS) || NUM_TAPS < 2 || NUM_CH < 1)
   begin : g_param_check
      $error("fir_mc_serial: ACC_WIDTH too narrow or NUM_TAPS/NUM_CH out of range");
   end

   state_t                      r_state, w_state_nxt;
   logic signed [IN_WIDTH-1:0]    r_taps [NUM_CH][NUM_TAPS];
   logic signed [COEFF_WIDTH-1:0] r_coef [NUM_TAPS];
   logic signed [ACC_WIDTH-1:0]   r_acc;
   logic [K_W-1:0]                r_k;
   logic [CH_W-1:0]               r_ch;
   logic signed [OUT_WIDTH-1:0]   r_out_data;
   logic [CH_W-1:0]               r_out_ch;
   logic                          r_out_sat;
   logic                          r_coef_err;

   logic                          w_accept, w_ch_ok, w_last, w_coef_ok;
   logic signed [P_W-1:0]         w_prod;
   logic signed [ACC_WIDTH-1:0]   w_acc_nxt;
   logic signed [OUT_WIDTH-1:0]   w_rs_value;
   logic                          w_rs_sat;

   // rst gates in_ready directly so no sample is taken while reset is held.
   assign in_ready  = (r_state == IDLE) && !rst;
   assign out_valid = (r_state == HOLD);
   assign out_data  = r_out_data;
   assign out_ch    = r_out_ch;
   assign out_sat   = r_out_sat;
   assign coef_err  = r_coef_err;

   assign w_accept  = in_valid && in_ready;
   assign w_ch_ok   = int'(in_ch) < NUM_CH;
   assign w_coef_ok = int'(coef_addr) < NUM_TAPS;
   assign w_last    = (r_k == K_W'(NUM_TAPS - 1));
   assign w_prod    = P_W'(r_taps[r_ch][r_k]) * P_W'(r_coef[r_k]);
   assign w_acc_nxt = r_acc + ACC_WIDTH'(w_prod);

   // The final tap's sum goes straight to rounding so the result lands with the last MAC.
   fir_round_sat #(
      .ACC_WIDTH (ACC_WIDTH),
      .FRAC_BITS (FRAC_BITS),
      .OUT_WIDTH (OUT_WIDTH)
   ) u_round_sat (
      .i_acc   (w_acc_nxt),
      .o_value (w_rs_value),
      .o_sat   (w_rs_sat)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (w_accept && w_ch_ok) w_state_nxt = MAC;
         MAC:     if (w_last) w_state_nxt = HOLD;
         HOLD:    if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++)
            for (int k = 0; k < NUM_TAPS; k++) r_taps[c][k] <= '0;
         for (int k = 0; k < NUM_TAPS; k++) r_coef[k] <= '0;
         r_acc      <= '0;
         r_k        <= '0;
         r_ch       <= '0;
         r_out_data <= '0;
         r_out_ch   <= '0;
         r_out_sat  <= 1'b0;
         r_coef_err <= 1'b0;
      end else begin
         r_coef_err <= coef_we && ((r_state != IDLE) || !w_coef_ok);
         if (coef_we && (r_state == IDLE) && w_coef_ok) r_coef[coef_addr] <= coef_data;
         case (r_state)
            IDLE: begin
               if (w_accept && w_ch_ok) begin
                  r_taps[in_ch][0] <= in_data;
                  for (int k = 1; k < NUM_TAPS; k++) r_taps[in_ch][k] <= r_taps[in_ch][k-1];
                  r_acc <= '0;
                  r_k   <= '0;
                  r_ch  <= in_ch;
               end
            end
            MAC: begin
               r_acc <= w_acc_nxt;
               r_k   <= r_k + 1'b1;
               if (w_last) begin
                  r_out_data <= w_rs_value;
                  r_out_sat  <= w_rs_sat;
                  r_out_ch   <= r_ch;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
